// File: rtl/spike_cmd_master.sv
// Initiator for the neuron command bus: forwards host commands and sequences
// simulation runs (tick cycles plus periodic input spike trains).
module spike_cmd_master #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned CMD_WIDTH    = 8,
    parameter int unsigned INT_WIDTH    = 8,
    parameter int unsigned INPUTS_COUNT = 2,
    parameter int unsigned TRAIN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [CMD_WIDTH-1:0]    req_cmd,
    input  logic [2*INT_WIDTH-1:0]  req_arg,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [CMD_WIDTH-1:0]    cmd,
    output logic [2*INT_WIDTH-1:0]  cmd_arg,
    output logic [INPUTS_COUNT-1:0] spike,
    output logic                    busy,
    output logic                    run_done,
    output logic [TRAIN_WIDTH-1:0]  tick_idx
);

    localparam int unsigned ARG_WIDTH = 2 * INT_WIDTH;

    localparam logic [CMD_WIDTH-1:0] CMD_NOP      = '1;
    localparam logic [CMD_WIDTH-1:0] CMD_RUN      = '0;
    localparam logic [CMD_WIDTH-1:0] CMD_SET_LEN  = CMD_NOP - CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] CMD_SET_FREQ = CMD_NOP - CMD_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [CMD_WIDTH-1:0]    cmd_d;
    logic [ARG_WIDTH-1:0]    cmd_arg_d;
    logic [INPUTS_COUNT-1:0] spike_d;
    logic                    busy_d;
    logic                    run_done_d;
    logic [TRAIN_WIDTH-1:0]  tick_idx_d;
    logic [TRAIN_WIDTH-1:0]  train_length, train_length_d;
    logic [TRAIN_WIDTH-1:0]  train_period, train_period_d;
    logic [INPUTS_COUNT-1:0] spike_mask, spike_mask_d;
    logic [TRAIN_WIDTH-1:0]  phase, phase_d;
    logic [TRAIN_WIDTH-1:0]  phase_next;
    logic                    accept;

    // Ready depends on state only so the host handshake has no comb loop
    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // Next-state and next-output computation; bus idles at NOP by default
    always_comb begin
        state_d        = state_q;
        addr_d         = '1;
        cmd_d          = CMD_NOP;
        cmd_arg_d      = '0;
        spike_d        = '0;
        busy_d         = 1'b0;
        run_done_d     = 1'b0;
        tick_idx_d     = tick_idx;
        train_length_d = train_length;
        train_period_d = train_period;
        spike_mask_d   = spike_mask;
        phase_d        = phase;
        phase_next     = (phase == train_period - TRAIN_WIDTH'(1)) ? '0 : phase + TRAIN_WIDTH'(1);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (req_cmd)
                        CMD_RUN: begin
                            spike_mask_d = req_arg[INPUTS_COUNT-1:0];
                            busy_d       = 1'b1;
                            if (train_length == '0) begin
                                state_d    = ST_DONE;
                                run_done_d = 1'b1;
                            end else begin
                                state_d    = ST_RUN;
                                cmd_d      = '0;
                                tick_idx_d = '0;
                                phase_d    = '0;
                                spike_d    = req_arg[INPUTS_COUNT-1:0]
                                           & {INPUTS_COUNT{train_period != '0}};
                            end
                        end
                        CMD_SET_LEN:  train_length_d = TRAIN_WIDTH'(req_arg);
                        CMD_SET_FREQ: train_period_d = TRAIN_WIDTH'(req_arg);
                        CMD_NOP:      ;
                        default: begin
                            addr_d    = req_addr;
                            cmd_d     = req_cmd;
                            cmd_arg_d = req_arg;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (tick_idx == train_length - TRAIN_WIDTH'(1)) begin
                    state_d    = ST_DONE;
                    run_done_d = 1'b1;
                end else begin
                    cmd_d      = '0;
                    tick_idx_d = tick_idx + TRAIN_WIDTH'(1);
                    phase_d    = phase_next;
                    spike_d    = spike_mask
                               & {INPUTS_COUNT{(train_period != '0) && (phase_next == '0)}};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, registered bus outputs and train configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr         <= '1;
            cmd          <= CMD_NOP;
            cmd_arg      <= '0;
            spike        <= '0;
            busy         <= 1'b0;
            run_done     <= 1'b0;
            tick_idx     <= '0;
            train_length <= TRAIN_WIDTH'(1);
            train_period <= TRAIN_WIDTH'(1);
            spike_mask   <= '0;
            phase        <= '0;
        end else begin
            state_q      <= state_d;
            addr         <= addr_d;
            cmd          <= cmd_d;
            cmd_arg      <= cmd_arg_d;
            spike        <= spike_d;
            busy         <= busy_d;
            run_done     <= run_done_d;
            tick_idx     <= tick_idx_d;
            train_length <= train_length_d;
            train_period <= train_period_d;
            spike_mask   <= spike_mask_d;
            phase        <= phase_d;
        end
    end

endmodule
